// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - CPU-wide CSR parameters and the CSR operation encoding
package cpu_params_pkg;

  localparam int RSZ = 32;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_WR   = 2'b01,
    CSR_SET  = 2'b10,
    CSR_CLR  = 2'b11
  } CSR_OP_T;

endpackage

// File: rtl/functions_pkg.sv
// rtl/functions_pkg.sv - pure helper functions shared by the CSR modules
package functions_pkg;

  import cpu_params_pkg::*;

  // Read-modify-write of one RSZ-bit CSR half for CSRRW/CSRRS/CSRRC.
  function automatic logic [RSZ-1:0] csr_wmod(
    input CSR_OP_T        op,
    input logic [RSZ-1:0] old,
    input logic [RSZ-1:0] wdata
  );
    logic [RSZ-1:0] res;
    res = old;
    case (op)
      CSR_WR:  res = wdata;
      CSR_SET: res = old | wdata;
      CSR_CLR: res = old & ~wdata;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_cnt_ff.sv
// rtl/csr_cnt_ff.sv - CSR counter register with RO masking, CSR write-modify and increment
module csr_cnt_ff
  import cpu_params_pkg::*;
  import functions_pkg::*;
#(
  parameter int               CNT_W      = 64,
  parameter int               INC_W      = 2,
  parameter logic [CNT_W-1:0] INIT_VALUE = '0,
  parameter logic [CNT_W-1:0] ROmask     = '0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             csr_wr,
  input  logic [1:0]       csr_op,
  input  logic             csr_sel_hi,
  input  logic [RSZ-1:0]   csr_wdata,
  input  logic             inhibit,
  input  logic [INC_W-1:0] inc_amt,
  output logic [CNT_W-1:0] cnt_out,
  output logic [RSZ-1:0]   csr_rdata,
  output logic             ovf
);

  if (!((CNT_W == RSZ) || (CNT_W == 2 * RSZ)) || (INC_W >= CNT_W)) begin : g_bad_width
    $error("csr_cnt_ff: CNT_W must be RSZ or 2*RSZ and INC_W must be below CNT_W");
  end

  CSR_OP_T          op;
  logic             wr_act;
  logic             inc_en;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] wr_val;
  logic [CNT_W-1:0] nxt;

  assign op     = CSR_OP_T'(csr_op);
  assign wr_act = csr_wr && (op != CSR_NONE);
  // A real CSR write drops this cycle's increment; a no-op access does not.
  assign inc_en = !inhibit && !wr_act;
  assign sum    = {1'b0, cnt_out} + {{(CNT_W + 1 - INC_W){1'b0}}, inc_amt};

  if (CNT_W == RSZ) begin : g_single
    always_comb begin
      wr_val = csr_wmod(op, cnt_out, csr_wdata);
    end
    assign csr_rdata = csr_sel_hi ? '0 : cnt_out;
  end else begin : g_dual
    always_comb begin
      wr_val = cnt_out;
      if (csr_sel_hi) begin
        wr_val[CNT_W-1:RSZ] = csr_wmod(op, cnt_out[CNT_W-1:RSZ], csr_wdata);
      end else begin
        wr_val[RSZ-1:0] = csr_wmod(op, cnt_out[RSZ-1:0], csr_wdata);
      end
    end
    assign csr_rdata = csr_sel_hi ? cnt_out[CNT_W-1:RSZ] : cnt_out[RSZ-1:0];
  end

  assign nxt = wr_act ? wr_val : (inc_en ? sum[CNT_W-1:0] : cnt_out);

  // RO bits are tied off, so a carry into them is simply lost.
  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    if (ROmask[i]) begin : g_ro
      assign cnt_out[i] = INIT_VALUE[i];
    end else begin : g_rw
      logic q;
      always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
          q <= INIT_VALUE[i];
        end else begin
          q <= nxt[i];
        end
      end
      assign cnt_out[i] = q;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ovf <= 1'b0;
    end else begin
      ovf <= inc_en && sum[CNT_W];
    end
  end

endmodule

// File: tb/tb_csr_cnt_ff.sv
// tb/tb_csr_cnt_ff.sv - scoreboard bench for csr_cnt_ff
module tb_csr_cnt_ff;

  logic        clk;
  logic        rst;
  logic        wr  [3];
  logic [1:0]  op  [3];
  logic        sel [3];
  logic [31:0] wd  [3];
  logic        inh [3];
  logic [1:0]  inc [3];

  logic [63:0] cnt_a, cnt_b;
  logic [31:0] cnt_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        ov_a, ov_b, ov_c;

  typedef struct {
    int          unit;
    logic [63:0] cnt;
    logic        ovf;
    logic [31:0] rd;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] ac;
  logic        ao;
  logic [31:0] ar;
  int          n_chk;
  int          n_fail;

  localparam logic [1:0] OW = 2'b01;
  localparam logic [1:0] OS = 2'b10;
  localparam logic [1:0] OC = 2'b11;

  csr_cnt_ff u_a (
    .clk_in(clk), .reset_in(rst), .csr_wr(wr[0]), .csr_op(op[0]), .csr_sel_hi(sel[0]),
    .csr_wdata(wd[0]), .inhibit(inh[0]), .inc_amt(inc[0]),
    .cnt_out(cnt_a), .csr_rdata(rd_a), .ovf(ov_a)
  );

  csr_cnt_ff #(.CNT_W(64), .INC_W(2), .INIT_VALUE(64'h1), .ROmask(64'h1)) u_b (
    .clk_in(clk), .reset_in(rst), .csr_wr(wr[1]), .csr_op(op[1]), .csr_sel_hi(sel[1]),
    .csr_wdata(wd[1]), .inhibit(inh[1]), .inc_amt(inc[1]),
    .cnt_out(cnt_b), .csr_rdata(rd_b), .ovf(ov_b)
  );

  csr_cnt_ff #(.CNT_W(32), .INC_W(2)) u_c (
    .clk_in(clk), .reset_in(rst), .csr_wr(wr[2]), .csr_op(op[2]), .csr_sel_hi(sel[2]),
    .csr_wdata(wd[2]), .inhibit(inh[2]), .inc_amt(inc[2]),
    .cnt_out(cnt_c), .csr_rdata(rd_c), .ovf(ov_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      wr[k] = 1'b0; op[k] = 2'b00; sel[k] = 1'b0; wd[k] = 32'h0; inh[k] = 1'b0; inc[k] = 2'd0;
    end
  endtask

  // Drive one cycle of stimulus on unit u and queue the result due after the edge.
  task automatic step(input int u, input logic w, input logic [1:0] o, input logic s,
                      input logic [31:0] d, input logic ih, input logic [1:0] ic,
                      input logic [63:0] ec, input logic eo, input logic [31:0] er,
                      input string nm);
    idle_all();
    wr[u] = w; op[u] = o; sel[u] = s; wd[u] = d; inh[u] = ih; inc[u] = ic;
    @(posedge clk);
    sb.push_back('{unit: u, cnt: ec, ovf: eo, rd: er, nm: nm});
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.unit)
        0:       begin ac = cnt_a;          ao = ov_a; ar = rd_a; end
        1:       begin ac = cnt_b;          ao = ov_b; ar = rd_b; end
        default: begin ac = {32'h0, cnt_c}; ao = ov_c; ar = rd_c; end
      endcase
      check({e.nm, " cnt"},   ac, e.cnt);
      check({e.nm, " ovf"},   {63'h0, ao}, {63'h0, e.ovf});
      check({e.nm, " rdata"}, {32'h0, ar}, {32'h0, e.rd});
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_all();
    #3;
    check("reset_a cnt", cnt_a, 64'h0);
    check("reset_a ovf", {63'h0, ov_a}, 64'h0);
    check("reset_b cnt", cnt_b, 64'h1);
    check("reset_c cnt", {32'h0, cnt_c}, 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'(k), 0, 32'(k), "inc5");
    end

    idle_all();
    rst = 1'b1;
    #2;
    check("async_rst cnt", cnt_a, 64'h0);
    check("async_rst ovf", {63'h0, ov_a}, 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    step(0, 1, OW, 0, 32'hFFFF_FFFF, 0, 2'd0, 64'h0000_0000_FFFF_FFFF, 0, 32'hFFFF_FFFF, "wr_lo");
    step(0, 0, 2'b00, 1, 32'h0, 0, 2'd1, 64'h0000_0001_0000_0000, 0, 32'h1, "carry_hi");
    step(0, 1, OW, 1, 32'hFFFF_FFFF, 0, 2'd0, 64'hFFFF_FFFF_0000_0000, 0, 32'hFFFF_FFFF, "wr_hi");
    step(0, 1, OW, 0, 32'hFFFF_FFFE, 0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32'hFFFF_FFFE, "wr_lo2");
    step(0, 0, 2'b00, 0, 32'h0, 0, 2'd3, 64'h1, 1, 32'h1, "wrap");
    step(0, 0, 2'b00, 0, 32'h0, 0, 2'd0, 64'h1, 0, 32'h1, "ovf_drop");
    step(0, 1, OW, 0, 32'h3, 0, 2'd0, 64'h3, 0, 32'h3, "wr_3");
    step(0, 1, OS, 0, 32'h10, 0, 2'd1, 64'h13, 0, 32'h13, "set_beats_inc");
    step(0, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'h14, 0, 32'h14, "inc_after_set");
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 2'b00, 0, 32'h0, 1, 2'd2, 64'h14, 0, 32'h14, "inhibit");
    end
    step(0, 1, OW, 0, 32'h1F, 0, 2'd0, 64'h1F, 0, 32'h1F, "wr_1f");
    step(0, 1, OC, 0, 32'hF, 0, 2'd0, 64'h10, 0, 32'h10, "clear");
    step(0, 1, 2'b00, 0, 32'hFFFF, 0, 2'd1, 64'h11, 0, 32'h11, "op_none_inc");
    step(0, 1, OS, 0, 32'h100, 1, 2'd1, 64'h111, 0, 32'h111, "wr_inhibited");
    step(0, 1, OW, 1, 32'hA, 0, 2'd0, 64'h0000_000A_0000_0111, 0, 32'hA, "b2b_hi");
    step(0, 1, OS, 0, 32'h1000, 0, 2'd0, 64'h0000_000A_0000_1111, 0, 32'h1111, "b2b_lo");
    step(0, 1, OW, 1, 32'h0, 0, 2'd3, 64'h1111, 0, 32'h0, "wr_hi_drops_inc");

    step(1, 1, OW, 0, 32'h0, 0, 2'd0, 64'h1, 0, 32'h1, "ro_wr");
    step(1, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'h3, 0, 32'h3, "ro_inc1");
    step(1, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'h5, 0, 32'h5, "ro_inc2");

    step(2, 1, OW, 1, 32'h1234, 0, 2'd0, 64'h1234, 0, 32'h0, "narrow_sel_hi");
    step(2, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'h1235, 0, 32'h1235, "narrow_inc");
    step(2, 1, OW, 0, 32'hFFFF_FFFF, 0, 2'd0, 64'hFFFF_FFFF, 0, 32'hFFFF_FFFF, "narrow_wr");
    step(2, 0, 2'b00, 0, 32'h0, 0, 2'd1, 64'h0, 1, 32'h0, "narrow_wrap");

    idle_all();
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_cnt_ff.md
# csr_cnt_ff

Parametrised successor to the plain CSR flop: a CNT_W-bit CSR counter register (mcycle/minstret/mhpmcounter class) with per-bit read-only masking, CSRRW/CSRRS/CSRRC write-modify on either 32-bit half, and a hardware increment path with inhibit. Instantiated inside the CSR file, once per counter. Software accesses come from the CSR instruction stage; increments come from the retire/cycle logic.

## Interface
- Parameters:
- CNT_W, 64, counter width; legal values are RSZ or 2*RSZ.
- INC_W, 2, width of the increment amount.
- INIT_VALUE, 0, reset value, CNT_W bits.
- ROmask, 0, CNT_W-bit mask; 1 = read-only bit, constant INIT_VALUE bit.
- Ports:
- clk_in  input  1  clock, one domain.
- reset_in  input  1  reset, asynchronous, active-high.
- csr_wr  input  1  CSR write strobe, one cycle per access.
- csr_op  input  2  CSR_OP_T: 01 write, 10 set, 11 clear, 00 none.
- csr_sel_hi  input  1  0 = bits [RSZ-1:0], 1 = bits [CNT_W-1:RSZ].
- csr_wdata  input  RSZ  write data, or set/clear mask.
- inhibit  input  1  mcountinhibit bit for this counter.
- inc_amt  input  INC_W  increment this cycle; 0 = none.
- cnt_out  output  CNT_W  full registered counter value.
- csr_rdata  output  RSZ  selected half of cnt_out, combinational.
- ovf  output  1  registered one-cycle pulse on wrap-around.

## Operation
- Write-modify on the selected half H, writable bits only:
  - write: H' = wdata
  - set: H' = H | wdata
  - clear: H' = H & ~wdata
  - csr_op 00 with csr_wr = 1: no change. The increment still applies.
- The unselected half holds its value on a CSR write. No carry propagates from a lo-half write into hi.
- Increment: when not inhibited and there is no CSR write, next = cnt + inc_amt, modulo 2^CNT_W. Carry crosses the half boundary.
- Priority, same cycle: CSR write (op != 00) beats the increment. The increment for that cycle is dropped, not deferred.
- inhibit = 1: increment suppressed. CSR writes still take effect.
- ROmask: bits with ROmask = 1 are constant INIT_VALUE in every cycle, including directly after increment or write. These bits are not flops. The mask is applied after the increment, so carry into an RO bit is lost.
- ovf: set the cycle after an increment wraps the writable value, i.e. the raw sum carries out of bit CNT_W-1. A CSR write never raises ovf.
- CNT_W == RSZ: csr_sel_hi is ignored for writes; csr_rdata reads 0 when csr_sel_hi = 1.

## Timing
- Reset, asynchronous: cnt_out = INIT_VALUE and ovf = 0 immediately, without waiting for a clock edge.
- Reset wins over any in-flight write or increment. The first update after release is on the first rising edge with reset_in = 0.
- CSR write latency: 1 cycle. The new value is on cnt_out/csr_rdata after the next rising edge.
- Same-cycle read returns the old value, matching the CSRRx read-before-write rule.
- Increment latency: 1 cycle.
- ovf is high for exactly one cycle, coincident with the wrapped value appearing on cnt_out.
- csr_rdata is combinational from the cnt_out flops and csr_sel_hi. There is no path from csr_wdata to csr_rdata.
- There is no handshake. csr_wr is a single-cycle qualifier; back-to-back writes on consecutive cycles are all applied, in order.

## Structure
- cpu_params_pkg:
  - CSR_OP_T enum (CSR_NONE, CSR_WR, CSR_SET, CSR_CLR).
  - RSZ.
- functions_pkg: pure function csr_wmod(op, old, wdata) returning the write-modified half. It is shared with the other CSR modules.
- Per-bit generate loop over CNT_W:
  - RO bits: constant assign.
  - Writable bits: async-reset flop.
- No sub-module. Width legality is checked by an elaboration-time assertion: CNT_W is RSZ or 2*RSZ, and INC_W is less than CNT_W.

## Test plan
- Reset, then inc_amt = 1 with inhibit = 0 for 5 cycles -> cnt_out = 5, ovf = 0. Asserting reset_in mid-clock -> cnt_out = INIT_VALUE before the next edge.
- Preload lo = 0xFFFF_FFFF (write, sel_hi = 0), then increment by 1 -> cnt_out = 0x1_0000_0000. csr_rdata with sel_hi = 1 reads 0x1.
- Write hi = 0xFFFF_FFFF and lo = 0xFFFF_FFFE, then inc_amt = 3 -> cnt_out = 0x1 and ovf pulses for 1 cycle.
- Same cycle: csr_wr with op = set, wdata = 0x10 on lo = 0x3, plus inc_amt = 1 -> lo = 0x13, increment dropped. Next cycle, increment only -> 0x14.
- inhibit = 1 with inc_amt = 2 for 10 cycles -> value unchanged. Clear with wdata = 0xF on lo = 0x1F -> lo = 0x10.
- ROmask = 0x1, INIT_VALUE = 0x1, write lo = 0x0 -> lo reads 0x1. Increment by 1 from 0x1 -> 0x3, because bit 0 stays forced.
